sprite_animator: RTL
====================

Name: sprite_animator

Overview:
- Parametrised successor to the single-frame, full-screen sprite example modules.
- Renders one animated sprite at a runtime screen position, scaled from SPR_W x SPR_H texels to a BOX_W x BOX_H hitbox, with optional horizontal mirror.
- Drives an external multi-frame sprite ROM that has 1-cycle registered read latency; frames are stored contiguously.
- Emits a palette index plus an opaque-hit flag, pipeline-aligned, for the top-level pixel mux/compositor.

Parameters:
- SPR_W, 60, sprite texel width.
- SPR_H, 90, sprite texel height.
- BOX_W, 80, on-screen hitbox width in pixels.
- BOX_H, 160, on-screen hitbox height in pixels.
- NUM_FRAMES, 6, animation frames in ROM; must be >= 1.
- FRAME_HOLD, 6, frame_tick pulses each frame is shown; must be >= 1.
- ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*SPR_W*SPR_H.
- IDX_W, 3, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.

Ports:
- vga_clk, in, 1, pixel clock; all logic on posedge.
- Reset, in, 1, synchronous, active-high.
- DrawX, in, 10, current pixel column.
- DrawY, in, 10, current pixel row.
- blank, in, 1, 1 = active video (codebase polarity).
- frame_tick, in, 1, single-cycle pulse once per video frame (start of vertical blank).
- pos_x, in, 10, hitbox left edge.
- pos_y, in, 10, hitbox top edge.
- flip, in, 1, 1 = mirror horizontally.
- anim_en, in, 1, 1 = advance animation.
- anim_loop, in, 1, 1 = wrap after last frame; 0 = one-shot.
- anim_restart, in, 1, pulse requesting restart from frame 0.
- rom_addr, out, ADDR_W, ROM address (registered).
- rom_q, in, IDX_W, ROM data, valid 1 cycle after rom_addr.
- pix_idx, out, IDX_W, palette index for the current output pixel.
- pix_hit, out, 1, 1 = opaque sprite pixel.
- frame_idx, out, ceil(log2(NUM_FRAMES)) (min 1), displayed frame number.
- anim_done, out, 1, one-shot sequence finished (level).

Behaviour:
- Reset: rom_addr=0, pix_idx=0, pix_hit=0, frame_idx=0, anim_done=0, hold_cnt=0, restart_pend=0, state=IDLE, and latched pos/flip = 0.
- Tear-free latching: pos_x, pos_y and flip are captured into shadow registers only on frame_tick. Mid-frame changes are invisible until the next tick.
- Stage 1 (cycle N+1, from DrawX/DrawY at N):
  - rel_x = DrawX - pos_x, rel_y = DrawY - pos_y, computed as 11-bit signed.
  - in_box = 0 <= rel_x < BOX_W and 0 <= rel_y < BOX_H.
  - sx = floor(rel_x*SPR_W/BOX_W), sy = floor(rel_y*SPR_H/BOX_H). Intermediate products are wide enough not to overflow.
  - If flip, sx = SPR_W-1-sx.
  - rom_addr = frame_idx*SPR_W*SPR_H + sy*SPR_W + sx when in_box, else 0.
  - in_box and blank are delayed alongside.
- Stage 2: ROM returns rom_q at cycle N+2.
- Stage 3 (cycle N+3):
  - pix_idx = rom_q when (in_box_d and blank_d), else 0.
  - pix_hit = in_box_d and blank_d and rom_q != TRANSP_IDX.
  - Fixed latency: 3 cycles from DrawX/DrawY to pix_idx/pix_hit.
- Hitbox partly off-screen (pos_x + BOX_W > 640): clips naturally; no wrap-around, because comparisons are signed.
- Animation FSM states: IDLE, PLAY, DONE.
  - anim_restart sets restart_pend (sticky). Restart is serviced only on frame_tick.
  - On frame_tick with restart_pend: frame_idx=0, hold_cnt=0, anim_done=0, restart_pend cleared; next state is PLAY if anim_en, else IDLE. Restart has priority over any advance on that tick.
  - IDLE: frame_idx frozen. On frame_tick with anim_en, go to PLAY (no advance on that tick).
  - PLAY: on each frame_tick, hold_cnt increments.
    - When hold_cnt reaches FRAME_HOLD-1 on a tick: hold_cnt resets to 0 and frame advances.
    - If frame_idx = NUM_FRAMES-1 and anim_loop: wrap to 0.
    - If frame_idx = NUM_FRAMES-1 and not anim_loop: stay on last frame, go to DONE, and anim_done=1.
    - anim_en=0 in PLAY: go to IDLE, keeping frame_idx and hold_cnt.
  - DONE: frame_idx held at NUM_FRAMES-1, anim_done held at 1. Leaves only via a serviced restart.
- frame_idx only ever changes on frame_tick cycles.
- Reset asserted mid-pipeline: all stages flush to 0 on the next edge. pix_hit stays 0 for 3 cycles after Reset deasserts.

Test Plan:
- Reset held 2 cycles, then released with blank=1 and DrawX=DrawY=0, pos_x=pos_y=0 not yet latched -> every output 0; pix_hit stays 0 until cycle 3 after release.
- pos_x=100, pos_y=50 latched by a frame_tick; frame 0, flip=0; DrawX=100, DrawY=50 -> rom_addr=0 at N+1. DrawX=179, DrawY=209 -> rom_addr=5399 (sx=59, sy=89).
- Same setup with flip=1; DrawX=100, DrawY=50 -> rom_addr=59. DrawX=99 -> in_box=0, rom_addr=0, pix_hit=0.
- ROM returns TRANSP_IDX=0 inside the box -> pix_hit=0, pix_idx=0. ROM returns 5 -> pix_hit=1, pix_idx=5 exactly 3 cycles after the DrawX sample.
- anim_en=1, anim_loop=1, FRAME_HOLD=6, NUM_FRAMES=6 -> frame_idx advances every 6 ticks (after the first tick, which only enters PLAY); wraps 5->0 at the 37th tick; frame_idx=2 gives frame base address 10800.
- anim_loop=0 -> after frame 5 finishes its hold, anim_done=1 and frame_idx stays 5. anim_restart pulsed mid-frame -> nothing changes until the next frame_tick, then frame_idx=0 and anim_done=0. pos_x changed mid-frame -> rom_addr unaffected until the next tick.

Source files
------------

// File: rtl/sprite_animator.sv
// Animated, scaled, optionally mirrored sprite renderer driving an external
// multi-frame ROM (1-cycle read latency); 3-cycle DrawX/DrawY to pixel latency.
module sprite_animator #(
  parameter int SPR_W      = 60,
  parameter int SPR_H      = 90,
  parameter int BOX_W      = 80,
  parameter int BOX_H      = 160,
  parameter int NUM_FRAMES = 6,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = 16,
  parameter int IDX_W      = 3,
  parameter int TRANSP_IDX = 0,
  localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               flip,
  input  logic               anim_en,
  input  logic               anim_loop,
  input  logic               anim_restart,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_hit,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               anim_done,
  output logic [1:0]         anim_state
);

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic signed [10:0] BOX_W_S = 11'(BOX_W);
  localparam logic signed [10:0] BOX_H_S = 11'(BOX_H);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DONE = 2'd2} anim_state_e;

  anim_state_e        state, state_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [FRAME_W-1:0] frame_n;
  logic               done_n, restart_pend, pend_n;
  logic [9:0]         pos_x_s, pos_y_s;
  logic               flip_s;

  assign anim_state = state;

  // Position and mirror only change at frame boundaries so a sprite never tears.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_x_s <= '0;
      pos_y_s <= '0;
      flip_s  <= 1'b0;
    end else if (frame_tick) begin
      pos_x_s <= pos_x;
      pos_y_s <= pos_y;
      flip_s  <= flip;
    end
  end

  // Stage 1: hitbox test and texel address.
  logic signed [10:0] rel_x, rel_y;
  logic               in_box;
  logic [31:0]        sx_raw, sx_eff, sy_raw, addr_full;

  assign rel_x  = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x_s});
  assign rel_y  = $signed({1'b0, DrawY}) - $signed({1'b0, pos_y_s});
  assign in_box = (rel_x >= 11'sd0) && (rel_x < BOX_W_S) &&
                  (rel_y >= 11'sd0) && (rel_y < BOX_H_S);
  assign sx_raw = ({22'd0, rel_x[9:0]} * 32'(SPR_W)) / 32'(BOX_W);
  assign sy_raw = ({22'd0, rel_y[9:0]} * 32'(SPR_H)) / 32'(BOX_H);
  assign sx_eff = flip_s ? (32'(SPR_W - 1) - sx_raw) : sx_raw;
  assign addr_full = 32'(frame_idx) * 32'(SPR_W * SPR_H) + sy_raw * 32'(SPR_W) + sx_eff;

  logic in_box_d, blank_d, in_box_d2, blank_d2;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      in_box_d  <= 1'b0;
      blank_d   <= 1'b0;
      in_box_d2 <= 1'b0;
      blank_d2  <= 1'b0;
      pix_idx   <= '0;
      pix_hit   <= 1'b0;
    end else begin
      rom_addr  <= in_box ? ADDR_W'(addr_full) : '0;
      in_box_d  <= in_box;
      blank_d   <= blank;
      // Second delay lines these flags up with rom_q, which lags rom_addr by one.
      in_box_d2 <= in_box_d;
      blank_d2  <= blank_d;
      pix_idx   <= (in_box_d2 && blank_d2) ? rom_q : '0;
      pix_hit   <= in_box_d2 && blank_d2 && (rom_q != IDX_W'(TRANSP_IDX));
    end
  end

  // Animation FSM.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      frame_idx    <= '0;
      hold_cnt     <= '0;
      anim_done    <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      state        <= state_n;
      frame_idx    <= frame_n;
      hold_cnt     <= hold_n;
      anim_done    <= done_n;
      restart_pend <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    frame_n = frame_idx;
    hold_n  = hold_cnt;
    done_n  = anim_done;
    pend_n  = restart_pend | anim_restart;
    if (frame_tick && restart_pend) begin
      // A pending restart wins over any advance scheduled for this tick.
      frame_n = '0;
      hold_n  = '0;
      done_n  = 1'b0;
      pend_n  = anim_restart;
      state_n = anim_en ? S_PLAY : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (frame_tick && anim_en) state_n = S_PLAY;
        S_PLAY: begin
          if (!anim_en) begin
            state_n = S_IDLE;
          end else if (frame_tick) begin
            if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
              hold_n = '0;
              if (frame_idx == FRAME_W'(NUM_FRAMES - 1)) begin
                if (anim_loop) begin
                  frame_n = '0;
                end else begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
                end
              end else begin
                frame_n = frame_idx + FRAME_W'(1);
              end
            end else begin
              hold_n = hold_cnt + HOLD_W'(1);
            end
          end
        end
        S_DONE: begin
          frame_n = FRAME_W'(NUM_FRAMES - 1);
          done_n  = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule
